// File: rtl/id_issue_ctrl_if.sv
// ID-stage issue handshake: decoded-instruction fields, EX backpressure, flush and the WB retire port.
// Latency: n/a, wires only.
// Backpressure: EX drives ex_allowin; the controller returns go_id, idstop and allowin_id.
// Ports (master = ID stage / pipeline, slave = issue controller):
//   id_valid, rs_num, rt_num, use_rs, use_rt, wr_en, wr_num, is_muldiv, is_hilo : decoded instruction
//   ex_allowin, flush                                                           : pipeline control
//   wb_valid, wb_num                                                            : GPR write retiring this cycle
//   go_id, allowin_id, idstop                                                   : issue decision
interface id_issue_ctrl_if;
   logic       id_valid;
   logic [4:0] rs_num;
   logic [4:0] rt_num;
   logic       use_rs;
   logic       use_rt;
   logic       wr_en;
   logic [4:0] wr_num;
   logic       is_muldiv;
   logic       is_hilo;
   logic       ex_allowin;
   logic       flush;
   logic       wb_valid;
   logic [4:0] wb_num;
   logic       go_id;
   logic       allowin_id;
   logic       idstop;

   modport master (
      output id_valid, rs_num, rt_num, use_rs, use_rt, wr_en, wr_num,
             is_muldiv, is_hilo, ex_allowin, flush, wb_valid, wb_num,
      input  go_id, allowin_id, idstop
   );

   modport slave (
      input  id_valid, rs_num, rt_num, use_rs, use_rt, wr_en, wr_num,
             is_muldiv, is_hilo, ex_allowin, flush, wb_valid, wb_num,
      output go_id, allowin_id, idstop
   );
endinterface

// File: rtl/id_issue_ctrl.sv
// Scoreboard issue controller for the ID stage: RAW, scoreboard-saturation and mul/div-busy interlocks.
// Latency: 0 cycles; the decision is combinational, and the scoreboard updates at the clock edge.
// Backpressure: holds ID (idstop) on any hazard or when EX refuses (ex_allowin=0); flush drops without a bubble.
// Ports:
//   clk, rst_n    : clock, async active-low reset
//   bus (slave)   : decoded instruction, EX/flush control, WB retire, issue decision
//   stall_cause   : {mdb, sat, raw} for the instruction in ID
//   md_busy       : mul/div unit still busy
//   sb_pending    : some GPR has a pending write
//   stall_cycles  : saturating count of bubble cycles
module id_issue_ctrl #(
   parameter int MD_LAT = 8,
   parameter int CNT_W  = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   id_issue_ctrl_if.slave     bus,
   output logic [2:0]         stall_cause,
   output logic               md_busy,
   output logic               sb_pending,
   output logic [31:0]        stall_cycles
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [3:0]       MD_LOAD = 4'(MD_LAT);

   // Pending-write counters; $0 has no storage and always reads as zero.
   logic [CNT_W-1:0] cnt [1:31];
   logic [3:0]       md_cnt;

   logic [CNT_W-1:0] rs_cnt, rt_cnt, wr_cnt, wb_cnt;
   logic [31:0]      inc_vec, dec_vec;
   logic             raw, sat, mdb;

   // Counter read ports: each is a 31:1 mux, register 0 falls through to zero.
   always_comb begin
      rs_cnt     = '0;
      rt_cnt     = '0;
      wr_cnt     = '0;
      wb_cnt     = '0;
      sb_pending = 1'b0;
      for (int i = 1; i < 32; i++) begin
         if (bus.rs_num == 5'(i)) rs_cnt = cnt[i];
         if (bus.rt_num == 5'(i)) rt_cnt = cnt[i];
         if (bus.wr_num == 5'(i)) wr_cnt = cnt[i];
         if (bus.wb_num == 5'(i)) wb_cnt = cnt[i];
         if (cnt[i] != '0) sb_pending = 1'b1;
      end
   end

   // No forwarding: a same-cycle retire does not clear raw, the register
   // file only holds the value after this edge.
   assign raw = (bus.use_rs && (bus.rs_num != 5'd0) && (rs_cnt != '0)) ||
                (bus.use_rt && (bus.rt_num != 5'd0) && (rt_cnt != '0));
   assign sat = bus.wr_en && (bus.wr_num != 5'd0) && (wr_cnt == CNT_MAX);
   assign mdb = (bus.is_muldiv || bus.is_hilo) && (md_cnt != 4'd0);

   assign stall_cause    = {mdb, sat, raw} & {3{bus.id_valid}};
   assign bus.go_id      = bus.id_valid && bus.ex_allowin && !bus.flush && !raw && !sat && !mdb;
   assign bus.idstop     = bus.id_valid && !bus.flush && !bus.go_id;
   assign bus.allowin_id = bus.go_id || !bus.id_valid || bus.flush;
   assign md_busy        = (md_cnt != 4'd0);

   always_comb begin
      inc_vec = '0;
      dec_vec = '0;
      for (int i = 1; i < 32; i++) begin
         inc_vec[i] = bus.go_id && bus.wr_en && (bus.wr_num == 5'(i));
         dec_vec[i] = bus.wb_valid && (bus.wb_num == 5'(i));
      end
   end

   // inc and dec together cancel; a decrement of an empty counter is ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 1; r < 32; r++) cnt[r] <= '0;
      end else begin
         for (int r = 1; r < 32; r++) begin
            if (inc_vec[r] && !dec_vec[r])
               cnt[r] <= cnt[r] + CNT_W'(1);
            else if (dec_vec[r] && !inc_vec[r] && (cnt[r] != '0))
               cnt[r] <= cnt[r] - CNT_W'(1);
         end
      end
   end

   // A mul/div can only issue when md_cnt is already zero (mdb), so the load never truncates a busy period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         md_cnt <= 4'd0;
      else if (bus.go_id && bus.is_muldiv)
         md_cnt <= MD_LOAD;
      else if (md_cnt != 4'd0)
         md_cnt <= md_cnt - 4'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cycles <= 32'd0;
      else if (bus.idstop && (stall_cycles != 32'hFFFF_FFFF))
         stall_cycles <= stall_cycles + 32'd1;
   end

   // A retire for a register with nothing pending means WB and the scoreboard disagree.
   wb_underflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(bus.wb_valid && (bus.wb_num != 5'd0) && (wb_cnt == '0) &&
        !(bus.go_id && bus.wr_en && (bus.wr_num == bus.wb_num))));

endmodule

// File: tb/tb_id_issue_ctrl.sv
module tb_id_issue_ctrl;
   localparam int MD_LAT = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  stall_cause;
   logic        md_busy;
   logic        sb_pending;
   logic [31:0] stall_cycles;
   int          n_tests = 0;
   int          n_fail  = 0;
   int          stalls;

   id_issue_ctrl_if bus();

   id_issue_ctrl #(.MD_LAT(MD_LAT), .CNT_W(2)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus),
      .stall_cause  (stall_cause),
      .md_busy      (md_busy),
      .sb_pending   (sb_pending),
      .stall_cycles (stall_cycles)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; checks run 1 unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.id_valid   = 1'b0;
      bus.rs_num     = 5'd0;
      bus.rt_num     = 5'd0;
      bus.use_rs     = 1'b0;
      bus.use_rt     = 1'b0;
      bus.wr_en      = 1'b0;
      bus.wr_num     = 5'd0;
      bus.is_muldiv  = 1'b0;
      bus.is_hilo    = 1'b0;
      bus.ex_allowin = 1'b1;
      bus.flush      = 1'b0;
      bus.wb_valid   = 1'b0;
      bus.wb_num     = 5'd0;
   endtask

   task automatic writer(input logic [4:0] rd);
      idle();
      bus.id_valid = 1'b1;
      bus.wr_en    = 1'b1;
      bus.wr_num   = rd;
   endtask

   task automatic reader(input logic [4:0] rs);
      idle();
      bus.id_valid = 1'b1;
      bus.use_rs   = 1'b1;
      bus.rs_num   = rs;
   endtask

   task automatic muldiv();
      idle();
      bus.id_valid  = 1'b1;
      bus.is_muldiv = 1'b1;
   endtask

   task automatic hilo();
      idle();
      bus.id_valid = 1'b1;
      bus.is_hilo  = 1'b1;
   endtask

   initial begin
      // Reset state
      rst_n = 1'b0;
      idle();
      #2;
      check("rst_md_busy", 32'(md_busy), 32'd0);
      check("rst_sb_pending", 32'(sb_pending), 32'd0);
      check("rst_stall_cycles", stall_cycles, 32'd0);
      bus.id_valid = 1'b1;
      #1;
      check("rst_go_id", 32'(bus.go_id), 32'd1);
      check("rst_stall_cause", 32'(stall_cause), 32'd0);
      idle();
      #10 rst_n = 1'b1;
      tick();

      // Build state, then reset asynchronously between edges
      writer(5'd5);
      #1 check("pre_go_wr5", 32'(bus.go_id), 32'd1);
      tick();
      muldiv();
      #1 check("pre_go_div", 32'(bus.go_id), 32'd1);
      tick();
      idle();
      bus.id_valid   = 1'b1;
      bus.ex_allowin = 1'b0;
      #1;
      check("bp_go_id", 32'(bus.go_id), 32'd0);
      check("bp_idstop", 32'(bus.idstop), 32'd1);
      check("bp_cause", 32'(stall_cause), 32'd0);
      check("bp_allowin", 32'(bus.allowin_id), 32'd0);
      tick();
      idle();
      #1;
      check("pre_md_busy", 32'(md_busy), 32'd1);
      check("pre_sb_pending", 32'(sb_pending), 32'd1);
      check("pre_stall_cycles", stall_cycles, 32'd1);
      check("idle_allowin", 32'(bus.allowin_id), 32'd1);
      tick();
      #1 rst_n = 1'b0;
      #1;
      check("arst_sb_pending", 32'(sb_pending), 32'd0);
      check("arst_md_busy", 32'(md_busy), 32'd0);
      check("arst_stall_cycles", stall_cycles, 32'd0);
      #2 rst_n = 1'b1;
      tick();

      // RAW on $5, retire in the third stall cycle
      writer(5'd5);
      #1 check("raw_prod_go", 32'(bus.go_id), 32'd1);
      tick();
      for (int i = 0; i < 3; i++) begin
         reader(5'd5);
         if (i == 2) begin
            bus.wb_valid = 1'b1;
            bus.wb_num   = 5'd5;
         end
         #1;
         check("raw_go", 32'(bus.go_id), 32'd0);
         check("raw_idstop", 32'(bus.idstop), 32'd1);
         check("raw_cause", 32'(stall_cause), 32'd1);
         tick();
      end
      reader(5'd5);
      #1;
      check("raw_release_go", 32'(bus.go_id), 32'd1);
      check("raw_release_cause", 32'(stall_cause), 32'd0);
      check("raw_stall_cycles", stall_cycles, 32'd3);
      tick();

      // $0 is never tracked
      writer(5'd0);
      #1 check("r0_wr_go", 32'(bus.go_id), 32'd1);
      tick();
      reader(5'd0);
      bus.use_rt = 1'b1;
      #1;
      check("r0_rd_go", 32'(bus.go_id), 32'd1);
      check("r0_sb_pending", 32'(sb_pending), 32'd0);
      tick();

      // Saturation of $8 (CNT_W=2 -> 3 outstanding)
      for (int i = 0; i < 3; i++) begin
         writer(5'd8);
         #1 check("sat_fill_go", 32'(bus.go_id), 32'd1);
         tick();
      end
      writer(5'd8);
      bus.wb_valid = 1'b1;
      bus.wb_num   = 5'd8;
      #1;
      check("sat_cause", 32'(stall_cause), 32'd2);
      check("sat_go", 32'(bus.go_id), 32'd0);
      tick();
      writer(5'd8);
      #1 check("sat_release_go", 32'(bus.go_id), 32'd1);
      tick();
      for (int i = 0; i < 3; i++) begin
         idle();
         bus.wb_valid = 1'b1;
         bus.wb_num   = 5'd8;
         tick();
      end
      idle();
      #1 check("sat_drain_pending", 32'(sb_pending), 32'd0);

      // Simultaneous inc/dec on $9 keeps the count at 1
      writer(5'd9);
      tick();
      writer(5'd9);
      bus.wb_valid = 1'b1;
      bus.wb_num   = 5'd9;
      #1 check("incdec_go", 32'(bus.go_id), 32'd1);
      tick();
      reader(5'd9);
      bus.wb_valid = 1'b1;
      bus.wb_num   = 5'd9;
      #1 check("incdec_still_pending", 32'(stall_cause), 32'd1);
      tick();
      reader(5'd9);
      #1;
      check("incdec_one_retire_go", 32'(bus.go_id), 32'd1);
      check("incdec_sb_pending", 32'(sb_pending), 32'd0);
      tick();

      // div followed by mflo
      muldiv();
      #1 check("md_div_go", 32'(bus.go_id), 32'd1);
      tick();
      stalls = 0;
      hilo();
      for (int k = 0; k < 20; k++) begin
         #1;
         if (bus.go_id) break;
         if (k == 0) check("md_cause", 32'(stall_cause), 32'd4);
         stalls++;
         tick();
      end
      check("md_stall_count", 32'(stalls), 32'(MD_LAT));
      check("md_busy_at_issue", 32'(md_busy), 32'd0);
      tick();

      // Flush during a mul/div stall: no bubble, no scoreboard effect
      muldiv();
      tick();
      hilo();
      #1 check("fl_pre_idstop", 32'(bus.idstop), 32'd1);
      tick();
      hilo();
      bus.wr_en  = 1'b1;
      bus.wr_num = 5'd10;
      bus.flush  = 1'b1;
      #1;
      check("fl_idstop", 32'(bus.idstop), 32'd0);
      check("fl_allowin", 32'(bus.allowin_id), 32'd1);
      check("fl_go", 32'(bus.go_id), 32'd0);
      tick();
      idle();
      #1;
      check("fl_sb_pending", 32'(sb_pending), 32'd0);
      check("total_stall_cycles", stall_cycles, 32'd14);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
